// File: rtl/sd_clk_gen_if.sv
// Card-clock generator bundle: controller-side controls in, card clock and status out.
// master = the clock generator, slave = the SD controller / SPI shifter side.
interface sd_clk_gen_if #(
  parameter int DIV_W   = 8,
  parameter int STATE_W = 8
);
  logic [STATE_W-1:0] State;
  logic               Enable;
  logic               ManualSel;
  logic [DIV_W-1:0]   DivManual;
  logic               CLKout;
  logic               RiseStrobe;
  logic               FallStrobe;
  logic [DIV_W-1:0]   ActiveDiv;
  logic               SwitchPending;
  logic               Parked;

  modport master (
    input  State, Enable, ManualSel, DivManual,
    output CLKout, RiseStrobe, FallStrobe, ActiveDiv, SwitchPending, Parked
  );

  modport slave (
    output State, Enable, ManualSel, DivManual,
    input  CLKout, RiseStrobe, FallStrobe, ActiveDiv, SwitchPending, Parked
  );
endinterface

// File: rtl/sd_clk_gen.sv
// Glitch-free SD card clock divider with auto/manual half-period select, park-low and edge strobes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ST_PARK | clock held low, cnt held at 0, divisor tracks target every cycle
//   ST_RUN  | clock toggling; divisor reloads only on high->low terminal count
module sd_clk_gen #(
  parameter int                 DIV_W      = 8,
  parameter int                 STATE_W    = 8,
  parameter logic [DIV_W-1:0]   SLOW_DIV   = DIV_W'(31),
  parameter logic [DIV_W-1:0]   FAST_DIV   = DIV_W'(1),
  parameter logic [STATE_W-1:0] SLOW_LIMIT = STATE_W'('h70)
) (
  input  logic            CLKin,
  input  logic            Reset_n,
  sd_clk_gen_if.master    bus
);

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               clk_q, clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               sw_q, sw_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   target;
  logic               slow_sel;
  logic               tc;

  always_comb begin
    slow_sel = (bus.State != '0) && (bus.State < SLOW_LIMIT);
    if (bus.ManualSel) begin
      target = bus.DivManual;
    end else if (slow_sel) begin
      target = SLOW_DIV;
    end else begin
      target = FAST_DIV;
    end
    tc = (cnt_q == div_q);
  end

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_PARK: begin
        clk_d = 1'b0;
        cnt_d = '0;
        div_d = target;
        if (bus.Enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tc) begin
          cnt_d = '0;
          if (clk_q) begin
            // High phase always completes; the new divisor governs the low phase that follows.
            clk_d  = 1'b0;
            fall_d = 1'b1;
            div_d  = target;
            if (!bus.Enable) begin
              state_d = ST_PARK;
            end
          end else if (!bus.Enable) begin
            state_d = ST_PARK;
          end else begin
            clk_d  = 1'b1;
            rise_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_PARK;
      end
    endcase
    // Compared against the divisor about to be in use so the flag clears on the loading edge.
    sw_d = (target != div_d);
  end

  always_ff @(posedge CLKin or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_PARK;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
      div_q   <= SLOW_DIV;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign bus.CLKout        = clk_q;
  assign bus.RiseStrobe    = rise_q;
  assign bus.FallStrobe    = fall_q;
  assign bus.ActiveDiv     = div_q;
  assign bus.SwitchPending = sw_q;
  assign bus.Parked        = (state_q == ST_PARK);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: expected clock edges are queued with their cycle numbers and
// matched against RiseStrobe/FallStrobe by a monitor; status outputs are checked inline.
module tb_sd_clk_gen;

  logic CLKin = 1'b0;
  logic Reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_on = 1'b0;
  logic prev_clk = 1'b0;

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t ev;

  sd_clk_gen_if #(.DIV_W(8), .STATE_W(8)) bus ();

  sd_clk_gen dut (
    .CLKin   (CLKin),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 CLKin = ~CLKin;
  always @(posedge CLKin) cyc <= cyc + 1;

  // Edge monitor: every CLKout edge must carry its strobe and match the next queued expectation.
  always @(negedge CLKin) begin
    if (mon_on) begin
      checks++;
      if (bus.RiseStrobe !== (bus.CLKout & ~prev_clk) || bus.FallStrobe !== (~bus.CLKout & prev_clk)) begin
        failures++;
        $display("FAIL strobe_vs_edge cyc=%0d clk=%b prev=%b rise=%b fall=%b", cyc, bus.CLKout, prev_clk,
                 bus.RiseStrobe, bus.FallStrobe);
      end
      if (bus.RiseStrobe === 1'b1 || bus.FallStrobe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_edge cyc=%0d rise=%b fall=%b expected none", cyc, bus.RiseStrobe, bus.FallStrobe);
        end else begin
          ev = exp_q.pop_front();
          if (ev.rise !== bus.RiseStrobe || ev.cyc != cyc) begin
            failures++;
            $display("FAIL edge_timing got rise=%b at cyc=%0d expected rise=%b at cyc=%0d",
                     bus.RiseStrobe, cyc, ev.rise, ev.cyc);
          end
        end
      end
    end
    prev_clk = bus.CLKout;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input bit r, input int c);
    ev_t e;
    e.rise = r;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge CLKin);
  endtask

  task automatic do_reset_start(input logic [7:0] st, input logic man, input logic [7:0] dm,
                                input logic en, output int e);
    @(negedge CLKin);
    mon_on        = 1'b0;
    Reset_n       = 1'b0;
    bus.State     = st;
    bus.ManualSel = man;
    bus.DivManual = dm;
    bus.Enable    = en;
    repeat (2) @(negedge CLKin);
    Reset_n = 1'b1;
    mon_on  = 1'b1;
    e = cyc + 1;
  endtask

  task automatic stop_run(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected 0 (next at cyc=%0d)", name, exp_q.size(), exp_q[0].cyc);
    end
    exp_q.delete();
    mon_on  = 1'b0;
    Reset_n = 1'b0;
  endtask

  task automatic test_reset();
    bus.State = 8'h00; bus.ManualSel = 1'b0; bus.DivManual = 8'h00; bus.Enable = 1'b0;
    repeat (3) @(negedge CLKin);
    checks += 6;
    if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL rst_clkout got=%b exp=0", bus.CLKout); end
    if (bus.RiseStrobe !== 1'b0) begin failures++; $display("FAIL rst_rise got=%b exp=0", bus.RiseStrobe); end
    if (bus.FallStrobe !== 1'b0) begin failures++; $display("FAIL rst_fall got=%b exp=0", bus.FallStrobe); end
    if (bus.ActiveDiv !== 8'd31) begin failures++; $display("FAIL rst_activediv got=%0d exp=31", bus.ActiveDiv); end
    if (bus.Parked !== 1'b1) begin failures++; $display("FAIL rst_parked got=%b exp=1", bus.Parked); end
    if (bus.SwitchPending !== 1'b0) begin failures++; $display("FAIL rst_swpend got=%b exp=0", bus.SwitchPending); end
    Reset_n = 1'b1;
    mon_on  = 1'b1;
    repeat (5) @(negedge CLKin);
    checks += 3;
    if (bus.Parked !== 1'b1) begin failures++; $display("FAIL idle_parked got=%b exp=1", bus.Parked); end
    if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL idle_clkout got=%b exp=0", bus.CLKout); end
    if (bus.ActiveDiv !== 8'd1) begin failures++; $display("FAIL idle_track got=%0d exp=1", bus.ActiveDiv); end
    stop_run("reset");
  endtask

  task automatic test_auto_slow();
    int e;
    do_reset_start(8'h10, 1'b0, 8'h00, 1'b1, e);
    push(1, e + 32); push(0, e + 64); push(1, e + 96); push(0, e + 128);
    wait_until(e);
    checks += 3;
    if (bus.Parked !== 1'b0) begin failures++; $display("FAIL slow_run got=%b exp=0", bus.Parked); end
    if (bus.ActiveDiv !== 8'd31) begin failures++; $display("FAIL slow_div got=%0d exp=31", bus.ActiveDiv); end
    if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL slow_start_low got=%b exp=0", bus.CLKout); end
    wait_until(e + 31);
    checks++;
    if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL slow_pre_rise got=%b exp=0", bus.CLKout); end
    wait_until(e + 129);
    stop_run("auto_slow");
  endtask

  task automatic test_auto_switch();
    int e;
    do_reset_start(8'h10, 1'b0, 8'h00, 1'b1, e);
    push(1, e + 32); push(0, e + 64); push(1, e + 96);
    wait_until(e + 100);
    bus.State = 8'h80;
    push(0, e + 128); push(1, e + 130); push(0, e + 132); push(1, e + 134); push(0, e + 136);
    wait_until(e + 101);
    checks += 2;
    if (bus.SwitchPending !== 1'b1) begin failures++; $display("FAIL sw_pend_set got=%b exp=1", bus.SwitchPending); end
    if (bus.ActiveDiv !== 8'd31) begin failures++; $display("FAIL sw_held_div got=%0d exp=31", bus.ActiveDiv); end
    wait_until(e + 127);
    checks += 2;
    if (bus.CLKout !== 1'b1) begin failures++; $display("FAIL sw_high_kept got=%b exp=1", bus.CLKout); end
    if (bus.SwitchPending !== 1'b1) begin failures++; $display("FAIL sw_pend_hold got=%b exp=1", bus.SwitchPending); end
    wait_until(e + 128);
    checks += 2;
    if (bus.ActiveDiv !== 8'd1) begin failures++; $display("FAIL sw_new_div got=%0d exp=1", bus.ActiveDiv); end
    if (bus.SwitchPending !== 1'b0) begin failures++; $display("FAIL sw_pend_clr got=%b exp=0", bus.SwitchPending); end
    wait_until(e + 137);
    stop_run("auto_switch");
  endtask

  task automatic test_boundary_decode();
    logic [7:0] st_tab [6] = '{8'h00, 8'h01, 8'h6F, 8'h70, 8'h80, 8'hFF};
    logic [7:0] dv_tab [6] = '{8'd1, 8'd31, 8'd31, 8'd1, 8'd1, 8'd1};
    int e;
    do_reset_start(8'h00, 1'b0, 8'h00, 1'b0, e);
    wait_until(e);
    for (int i = 0; i < 6; i++) begin
      bus.State = st_tab[i];
      @(negedge CLKin);
      checks += 2;
      if (bus.ActiveDiv !== dv_tab[i]) begin
        failures++; $display("FAIL decode_%0h got=%0d exp=%0d", st_tab[i], bus.ActiveDiv, dv_tab[i]);
      end
      if (bus.Parked !== 1'b1 || bus.SwitchPending !== 1'b0) begin
        failures++; $display("FAIL decode_park_%0h parked=%b swp=%b exp 1/0", st_tab[i], bus.Parked, bus.SwitchPending);
      end
    end
    bus.ManualSel = 1'b1; bus.DivManual = 8'h37;
    @(negedge CLKin);
    checks++;
    if (bus.ActiveDiv !== 8'h37) begin failures++; $display("FAIL decode_manual got=%0h exp=37", bus.ActiveDiv); end
    bus.ManualSel = 1'b0; bus.State = 8'h6F;
    @(negedge CLKin);
    checks++;
    if (bus.ActiveDiv !== 8'd31) begin failures++; $display("FAIL decode_unmanual got=%0d exp=31", bus.ActiveDiv); end
    bus.State = 8'h70; bus.Enable = 1'b1;
    e = cyc + 1;
    push(1, e + 2); push(0, e + 4);
    wait_until(e + 5);
    stop_run("decode");
  endtask

  task automatic test_park_resume();
    int e, p;
    do_reset_start(8'h10, 1'b1, 8'd3, 1'b1, e);
    push(1, e + 4); push(0, e + 8); push(1, e + 12);
    wait_until(e + 13);
    bus.Enable = 1'b0;
    push(0, e + 16);
    wait_until(e + 15);
    checks += 2;
    if (bus.Parked !== 1'b0) begin failures++; $display("FAIL park_early got=%b exp=0", bus.Parked); end
    if (bus.CLKout !== 1'b1) begin failures++; $display("FAIL park_high_done got=%b exp=1", bus.CLKout); end
    wait_until(e + 16);
    checks += 2;
    if (bus.Parked !== 1'b1) begin failures++; $display("FAIL park_entered got=%b exp=1", bus.Parked); end
    if (bus.ActiveDiv !== 8'd3) begin failures++; $display("FAIL park_div got=%0d exp=3", bus.ActiveDiv); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLKin);
      checks++;
      if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL park_stuck_low cyc=%0d got=%b exp=0", cyc, bus.CLKout); end
    end
    p = cyc;
    bus.DivManual = 8'd6;
    bus.Enable    = 1'b1;
    push(1, p + 8); push(0, p + 15);
    wait_until(p + 1);
    checks++;
    if (bus.ActiveDiv !== 8'd6 || bus.Parked !== 1'b0) begin
      failures++; $display("FAIL resume_div got=%0d parked=%b exp=6/0", bus.ActiveDiv, bus.Parked);
    end
    wait_until(p + 17);
    bus.Enable = 1'b0;
    wait_until(p + 21);
    checks++;
    if (bus.Parked !== 1'b0) begin failures++; $display("FAIL lowpark_early got=%b exp=0", bus.Parked); end
    wait_until(p + 22);
    checks++;
    if (bus.Parked !== 1'b1 || bus.CLKout !== 1'b0) begin
      failures++; $display("FAIL lowpark got parked=%b clk=%b exp=1/0", bus.Parked, bus.CLKout);
    end
    wait_until(p + 25);
    stop_run("park_resume");
  endtask

  task automatic test_manual();
    int e;
    do_reset_start(8'h10, 1'b1, 8'd0, 1'b1, e);
    push(1, e + 1); push(0, e + 2); push(1, e + 3); push(0, e + 4); push(1, e + 5); push(0, e + 6);
    wait_until(e + 6);
    bus.DivManual = 8'd5;
    push(1, e + 7); push(0, e + 8); push(1, e + 14); push(0, e + 20); push(1, e + 26); push(0, e + 32);
    wait_until(e + 7);
    checks += 2;
    if (bus.ActiveDiv !== 8'd0) begin failures++; $display("FAIL man_old_div got=%0d exp=0", bus.ActiveDiv); end
    if (bus.SwitchPending !== 1'b1) begin failures++; $display("FAIL man_pend got=%b exp=1", bus.SwitchPending); end
    wait_until(e + 8);
    checks++;
    if (bus.ActiveDiv !== 8'd5 || bus.SwitchPending !== 1'b0) begin
      failures++; $display("FAIL man_new_div got=%0d swp=%b exp=5/0", bus.ActiveDiv, bus.SwitchPending);
    end
    wait_until(e + 15);
    bus.DivManual = 8'd2;
    wait_until(e + 16);
    checks++;
    if (bus.SwitchPending !== 1'b1 || bus.ActiveDiv !== 8'd5) begin
      failures++; $display("FAIL flip_pend got swp=%b div=%0d exp=1/5", bus.SwitchPending, bus.ActiveDiv);
    end
    wait_until(e + 17);
    bus.DivManual = 8'd5;
    wait_until(e + 18);
    checks++;
    if (bus.SwitchPending !== 1'b0) begin failures++; $display("FAIL flip_back got=%b exp=0", bus.SwitchPending); end
    wait_until(e + 20);
    checks++;
    if (bus.ActiveDiv !== 8'd5) begin failures++; $display("FAIL flip_div got=%0d exp=5", bus.ActiveDiv); end
    wait_until(e + 33);
    stop_run("manual");
  endtask

  task automatic test_async_reset();
    int e;
    do_reset_start(8'h10, 1'b1, 8'd4, 1'b1, e);
    push(1, e + 5);
    wait_until(e + 7);
    checks++;
    if (bus.CLKout !== 1'b1 || bus.ActiveDiv !== 8'd4) begin
      failures++; $display("FAIL arst_pre got clk=%b div=%0d exp=1/4", bus.CLKout, bus.ActiveDiv);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL arst_pre_drain pending=%0d exp=0", exp_q.size()); end
    mon_on = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checks += 4;
    if (bus.CLKout !== 1'b0) begin failures++; $display("FAIL arst_clkout got=%b exp=0", bus.CLKout); end
    if (bus.ActiveDiv !== 8'd31) begin failures++; $display("FAIL arst_div got=%0d exp=31", bus.ActiveDiv); end
    if (bus.Parked !== 1'b1) begin failures++; $display("FAIL arst_parked got=%b exp=1", bus.Parked); end
    if (bus.RiseStrobe !== 1'b0 || bus.FallStrobe !== 1'b0 || bus.SwitchPending !== 1'b0) begin
      failures++; $display("FAIL arst_flags got r=%b f=%b s=%b exp=0/0/0", bus.RiseStrobe, bus.FallStrobe, bus.SwitchPending);
    end
    repeat (2) @(negedge CLKin);
    Reset_n = 1'b1;
    mon_on  = 1'b1;
    e = cyc + 1;
    push(1, e + 5); push(0, e + 10);
    wait_until(e);
    checks++;
    if (bus.ActiveDiv !== 8'd4 || bus.Parked !== 1'b0) begin
      failures++; $display("FAIL arst_resume got div=%0d parked=%b exp=4/0", bus.ActiveDiv, bus.Parked);
    end
    wait_until(e + 11);
    stop_run("async_reset");
  endtask

  initial begin
    bus.State = 8'h00; bus.ManualSel = 1'b0; bus.DivManual = 8'h00; bus.Enable = 1'b0;
    test_reset();
    test_auto_slow();
    test_auto_switch();
    test_boundary_decode();
    test_park_resume();
    test_manual();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
